// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage and the data-memory controller.
`timescale 1ns/1ps
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word access with extension, wait states,
// alignment/range faults, zero-clear after reset and a debug read port.
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int DEPTH          = 64,
  parameter int WAIT_CYCLES    = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_ctrl_if.slave    bus,
  output logic              busy,
  input  logic [AW-1:0]     dbg_addr,
  output logic [31:0]       dbg_data
);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : IDLE;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] init_cnt;
  logic [3:0]    wait_cnt;

  logic          cap_we, cap_uns;
  logic [1:0]    cap_size;
  logic [31:0]   cap_addr, cap_wdata;

  logic          cur_we, cur_uns;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   word, wd, ext;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  logic          err, accept, commit, mem_we, init_we;

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = (state == IDLE) && bus.req_valid;
  assign dbg_data      = mem[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (init_cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      IDLE: if (bus.req_valid) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == 4'(WAIT_CYCLES - 1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = RST_STATE;
    endcase
  end

  // Commit on the edge entering RESP; with no wait states that is the accept
  // edge itself, so the live bus is used instead of the captured copy.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_size  = bus.req_size;
      cur_uns   = bus.req_unsigned;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = cap_we;
      cur_size  = cap_size;
      cur_uns   = cap_uns;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
    end
    commit  = (state_nxt == RESP);
    err     = (cur_size == 2'b11)
            | ((cur_size == 2'b01) & cur_addr[0])
            | ((cur_size == 2'b10) & (|cur_addr[1:0]))
            | (|(cur_addr >> (AW + 2)));
    mem_we  = rst_n && commit && cur_we && !err;
    init_we = rst_n && (state == INIT);
  end

  // Lane selection for stores and extraction/extension for loads
  always_comb begin
    idx    = cur_addr[AW+1:2];
    word   = mem[idx];
    byte_v = word[{cur_addr[1:0], 3'b000} +: 8];
    half_v = word[{cur_addr[1], 4'b0000} +: 16];
    case (cur_size)
      2'b00: begin
        be  = 4'b0001 << cur_addr[1:0];
        wd  = {4{cur_wdata[7:0]}};
        ext = cur_uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be  = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{cur_wdata[15:0]}};
        ext = cur_uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        be  = 4'b1111;
        wd  = cur_wdata;
        ext = word;
      end
    endcase
  end

  // Counters, request capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt      <= '0;
      wait_cnt      <= '0;
      cap_we        <= 1'b0;
      cap_size      <= '0;
      cap_uns       <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (state == WAIT) wait_cnt <= (state_nxt == RESP) ? '0 : wait_cnt + 1'b1;
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_size  <= bus.req_size;
        cap_uns   <= bus.req_unsigned;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
      end
      bus.rsp_valid <= commit;
      if (commit) begin
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (cur_we || err) ? '0 : ext;
      end
    end
  end

  // Memory array: zero-clear during INIT, byte-lane store on commit
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end

endmodule
